wb_queue: RTL and testbench
===========================

// Module: wb_queue
// PURPOSE
//   Buffers the processor unit's register write-back stream (we/wd) for an external consumer.
//   Every cycle with we=1 offers wd to a circular FIFO; a downstream sink (display/host link)
//   drains entries through a valid/ready handshake. Overflows are flagged, never silently stalled,
//   because the processor has no back-pressure input.
// PARAMETERS
//   DW     16               data width; matches wd
//   DEPTH  8                entry count; power of two, >=2
//   AW     $clog2(DEPTH)    pointer width (derived, not overridden)
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous reset, active high
//   we         in   1       write-back strobe from the processor unit
//   wd         in   DW      write-back data from the processor unit
//   out_valid  out  1       head entry available
//   out_data   out  DW      head entry; 0 when empty
//   out_ready  in   1       sink accepts head this cycle
//   full       out  1       count==DEPTH
//   empty      out  1       count==0
//   count      out  AW+1    occupancy 0..DEPTH
//   ovf        out  1       sticky: a write was dropped
//   ovf_clr    in   1       synchronous clear of ovf
// BEHAVIOUR
//   - Reset (async, rst=1): wptr=rptr=0, count=0, ovf=0 -> out_valid=0, out_data=0, empty=1, full=0.
//     Storage contents are not reset. Reset mid-stream discards all entries immediately.
//   - push = we & (~full | pop); pop = out_valid & out_ready. Both evaluated on the pre-edge state.
//   - Push: mem[wptr]<=wd, wptr<=wptr+1 (wraps mod DEPTH). Pop: rptr<=rptr+1 (wraps mod DEPTH).
//   - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//   - Latency: an entry written at edge N is visible on out_data/out_valid after edge N; no
//     same-cycle bypass while empty (empty & we & out_ready -> no pop, entry appears next cycle).
//   - Full & we & pop: push accepted, slot reused in the same edge, count stays DEPTH, ovf unchanged.
//   - Full & we & ~pop: wd dropped, state unchanged, ovf<=1.
//   - ovf: set wins over ovf_clr on the same edge; otherwise ovf_clr=1 -> ovf<=0.
//   - out_valid=~empty; out_data=mem[rptr] when ~empty, else 0. Held stable while out_valid&~out_ready.
//   - pop while empty is impossible (out_valid=0); out_ready is ignored then.
// CONFIGURATION
//   WB_QUEUE_TAG_EN defined: adds port out_tag [7:0] out and an 8-bit seq counter (reset 0) that
//     increments on every we=1 cycle, dropped or not; each stored entry carries seq, so the
//     sink detects gaps. out_tag follows out_data rules (0 when empty). The counter wraps 255->0.
//   Not defined: no out_tag port, no counter, storage is DW bits wide.
// STRUCTURE
//   - wbq_pkg: WBQ_DW=16, WBQ_DEPTH=8 defaults; typedef logic [WBQ_DW-1:0] wbq_data_t;
//     typedef struct packed {logic [7:0] tag; wbq_data_t data;} wbq_entry_t (used with TAG_EN).
//   - Sub-module wbq_ram: DEPTH x entry array, one synchronous write port and one asynchronous
//     read port; no reset. All pointer/count/flag control stays in wb_queue.
// TESTING
//   1 rst=1 mid-run, then release -> out_valid=0, out_data=0, count=0, empty=1, ovf=0.
//   2 we=1 for 3 cycles wd=0x0011,0x0022,0x0033, out_ready=0 -> count=3; then out_ready=1 ->
//     out_data 0x0011,0x0022,0x0033 on consecutive cycles, then empty=1.
//   3 fill 8 (0x0100..0x0107), 9th we wd=0xDEAD with out_ready=0 -> dropped, ovf=1, count=8,
//     drain yields 0x0100..0x0107 only; ovf_clr=1 -> ovf=0.
//   4 full, we=1 wd=0xBEEF with out_ready=1 -> pops 0x0100, count stays 8, ovf=0, 0xBEEF is last out.
//   5 empty, we=1 wd=0x0042 with out_ready=1 -> no pop that cycle; next cycle out_valid=1,
//     out_data=0x0042; 20 push/pop cycles prove pointer wrap with in-order data.
//   6 TAG_EN: 10 we pulses with out_ready=0 (2 dropped) -> drained tags 0..7; next push tag=10;
//     after 256 we pulses tag wraps to 0.

Source files
------------

// File: rtl/wbq_pkg.sv
// Shared definitions for the write-back queue: default sizes, the data and
// entry types, and a helper that sizes a stored entry. The optional sequence
// tag is enabled by defining WB_QUEUE_TAG_EN.
package wbq_pkg;

  localparam int WBQ_DW    = 16;
  localparam int WBQ_DEPTH = 8;
  localparam int WBQ_TAG_W = 8;

  typedef logic [WBQ_DW-1:0] wbq_data_t;

  typedef struct packed {
    logic [7:0] tag;
    wbq_data_t  data;
  } wbq_entry_t;

  // Width of one stored entry: data alone, or tag concatenated above data.
  function automatic int wbq_entry_w(input int dw);
`ifdef WB_QUEUE_TAG_EN
    return dw + WBQ_TAG_W;
`else
    return dw;
`endif
  endfunction

endpackage

// File: rtl/wb_queue_if.sv
// Bundle of the write-back stream, the sink handshake and the status flags.
// master = processor/sink side, slave = the queue itself. Defining
// WB_QUEUE_TAG_EN adds the out_tag sequence field.
interface wb_queue_if
  import wbq_pkg::*;
#(
  parameter int DW    = WBQ_DW,
  parameter int DEPTH = WBQ_DEPTH
);

  localparam int AW = $clog2(DEPTH);

  logic          we;
  logic [DW-1:0] wd;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ovf;
  logic          ovf_clr;
`ifdef WB_QUEUE_TAG_EN
  logic [7:0]    out_tag;
`endif

  modport master (
    output we, wd, out_ready, ovf_clr,
    input  out_valid, out_data, full, empty, count, ovf
`ifdef WB_QUEUE_TAG_EN
    , input out_tag
`endif
  );

  modport slave (
    input  we, wd, out_ready, ovf_clr,
    output out_valid, out_data, full, empty, count, ovf
`ifdef WB_QUEUE_TAG_EN
    , output out_tag
`endif
  );

endinterface

// File: rtl/wbq_ram.sv
// Entry storage for the write-back queue: DEPTH words, one synchronous write
// port and one asynchronous read port. Contents are never reset; validity is
// tracked entirely by the pointers and count in wb_queue.
module wbq_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the addressed slot on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: captures every we=1 cycle of the processor's write-back
// stream into a circular FIFO that a sink drains with valid/ready. The
// processor cannot be stalled, so a write arriving while full with no pop is
// dropped and latched in the sticky ovf flag. Defining WB_QUEUE_TAG_EN stores
// an 8-bit sequence number with each entry and exposes it on out_tag.
module wb_queue
  import wbq_pkg::*;
#(
  parameter int DW    = WBQ_DW,
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  wb_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = wbq_entry_w(DW);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A pop frees the head slot in the same edge, so a full queue can still
  // accept a write when the sink is draining. No bypass while empty.
  assign pop  = ~empty & bus.out_ready;
  assign push = bus.we & (~full | pop);
  assign drop = bus.we & full & ~pop;

`ifdef WB_QUEUE_TAG_EN
  logic [WBQ_TAG_W-1:0] seq_q, seq_d;

  // Sequence number advances on every offered write, dropped or not, so the
  // sink can spot gaps left by overflow.
  always_comb begin
    seq_d = seq_q;
    if (bus.we) begin
      seq_d = seq_q + 1'b1;
    end
  end

  // Sequence counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign wr_entry    = {seq_q, bus.wd};
  assign bus.out_tag = empty ? '0 : rd_entry[EW-1 -: WBQ_TAG_W];
`else
  assign wr_entry = bus.wd;
`endif

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new drop outranks a clear on the same edge so no overflow is lost.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control state registers; reset discards all entries immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  wbq_ram #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .wr_en (push),
    .waddr (wptr_q),
    .wdata (wr_entry),
    .raddr (rptr_q),
    .rdata (rd_entry)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : rd_entry[DW-1:0];
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// queue-based reference model.
module tb_wb_queue;
  import wbq_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  wbq_entry_t mq[$];
  bit         m_ovf = 1'b0;
  logic [7:0] m_seq = 8'd0;

  wb_queue_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  wb_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf = 1'b0;
    m_seq = 8'd0;
  endtask

  // One clock edge of the queue behaviour, from the pre-edge model and inputs.
  task automatic model_step();
    bit m_full, m_pop, m_push;
    wbq_entry_t e;
    m_full = (mq.size() == DEPTH);
    m_pop  = (mq.size() != 0) && bus.out_ready;
    m_push = bus.we && (!m_full || m_pop);
    if (bus.we && m_full && !m_pop) m_ovf = 1'b1;
    else if (bus.ovf_clr)           m_ovf = 1'b0;
    if (m_pop) void'(mq.pop_front());
    if (m_push) begin
      e.tag  = m_seq;
      e.data = bus.wd;
      mq.push_back(e);
    end
    if (bus.we) m_seq = m_seq + 8'd1;
  endtask

  // Called at a falling edge: apply inputs, take one rising edge, return at
  // the next falling edge.
  task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic c);
    bus.we        = w;
    bus.wd        = d;
    bus.out_ready = r;
    bus.ovf_clr   = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Every cycle outside reset, the DUT outputs must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
      chk("data",  {16'd0, bus.out_data},  (mq.size() != 0) ? {16'd0, mq[0].data} : 32'd0);
      chk("count", {27'd0, bus.count},     mq.size());
      chk("full",  {31'd0, bus.full},      {31'd0, mq.size() == DEPTH});
      chk("empty", {31'd0, bus.empty},     {31'd0, mq.size() == 0});
      chk("ovf",   {31'd0, bus.ovf},       {31'd0, m_ovf});
`ifdef WB_QUEUE_TAG_EN
      chk("tag",   {24'd0, bus.out_tag},   (mq.size() != 0) ? {24'd0, mq[0].tag} : 32'd0);
`endif
    end
  end

  initial begin
    int rdy_pct;
    bus.we = 1'b0; bus.wd = '0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);

    // Reset in the middle of a stream discards entries at once.
    cyc(1'b1, 16'h0055, 1'b0, 1'b0);
    cyc(1'b1, 16'h0056, 1'b0, 1'b0);
    chk("pre_rst_count", {27'd0, bus.count}, 32'd2);
    rst = 1'b1;
    model_clear();
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_data",  {16'd0, bus.out_data},  32'd0);
    chk("mid_rst_count", {27'd0, bus.count},     32'd0);
    chk("mid_rst_empty", {31'd0, bus.empty},     32'd1);
    chk("mid_rst_full",  {31'd0, bus.full},      32'd0);
    chk("mid_rst_ovf",   {31'd0, bus.ovf},       32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Three writes held, then drained in order.
    cyc(1'b1, 16'h0011, 1'b0, 1'b0);
    cyc(1'b1, 16'h0022, 1'b0, 1'b0);
    cyc(1'b1, 16'h0033, 1'b0, 1'b0);
    chk("t2_count", {27'd0, bus.count}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_data", {16'd0, bus.out_data}, 32'h11 * (i + 1));
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    chk("t2_empty", {31'd0, bus.empty}, 32'd1);

    // Fill, overflow, set-beats-clear, drain, then clear.
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    chk("t3_full", {31'd0, bus.full}, 32'd1);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("t3_ovf", {31'd0, bus.ovf}, 32'd1);
    chk("t3_count", {27'd0, bus.count}, 32'd8);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b1);
    chk("t3_ovf_setwins", {31'd0, bus.ovf}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", {16'd0, bus.out_data}, 32'h0100 + i);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    chk("t3_empty", {31'd0, bus.empty}, 32'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("t3_ovf_clr", {31'd0, bus.ovf}, 32'd0);

    // Full with a simultaneous pop accepts the write.
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("t4_count", {27'd0, bus.count}, 32'd8);
    chk("t4_ovf", {31'd0, bus.ovf}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain", {16'd0, bus.out_data}, (i == 7) ? 32'hBEEF : 32'h0101 + i);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end

    // No bypass while empty, then streaming push/pop across pointer wrap.
    cyc(1'b1, 16'h0042, 1'b1, 1'b0);
    chk("t5_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t5_data", {16'd0, bus.out_data}, 32'h0042);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 16'h0200 + 16'(i), 1'b1, 1'b0);
      chk("t5_stream", {16'd0, bus.out_data}, 32'h0200 + i);
      chk("t5_count", {27'd0, bus.count}, 32'd1);
    end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);

`ifdef WB_QUEUE_TAG_EN
    // Tags count every offered write, so dropped writes leave gaps.
    reset_pulse();
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("t6_tag", {24'd0, bus.out_tag}, i);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    cyc(1'b1, 16'h0077, 1'b0, 1'b0);
    chk("t6_tag10", {24'd0, bus.out_tag}, 32'd10);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 245; i++) cyc(1'b1, 16'($urandom), 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b1, 16'h0099, 1'b0, 1'b0);
    chk("t6_tag_wrap", {24'd0, bus.out_tag}, 32'd0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
`endif

    // Randomized traffic with alternating drain pressure and rare resets.
    rdy_pct = 30;
    for (int n = 0; n < 3000; n++) begin
      if ((n % 200) == 0) rdy_pct = (rdy_pct == 30) ? 85 : 30;
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse();
      end else begin
        cyc($urandom_range(0, 99) < 60,
            16'($urandom),
            $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 99) < 5);
      end
    end

    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
